// File: rtl/alu_cmd_driver_pkg.sv
// Shared definitions for the ALU command driver: default widths, ALU command codes,
// FSM state encoding and response flag bit positions.
package alu_cmd_driver_pkg;

  localparam int unsigned ALU_OP_WIDTH  = 8;
  localparam int unsigned ALU_CMD_WIDTH = 4;

  // Arithmetic-mode (mode=1) command codes understood by the ALU.
  typedef enum logic [3:0] {
    ADD     = 4'd0,
    SUB     = 4'd1,
    ADD_CIN = 4'd2,
    SUB_CIN = 4'd3,
    INC_A   = 4'd4,
    DEC_A   = 4'd5,
    INC_B   = 4'd6,
    DEC_B   = 4'd7,
    CMP     = 4'd8,
    INC_MUL = 4'd9,
    SHL_MUL = 4'd10
  } alu_arith_cmd_e;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam int unsigned FLAG_COUT  = 0;
  localparam int unsigned FLAG_OFLOW = 1;
  localparam int unsigned FLAG_G     = 2;
  localparam int unsigned FLAG_L     = 3;
  localparam int unsigned FLAG_E     = 4;
  localparam int unsigned FLAG_ERR   = 5;

endpackage

// File: rtl/alu_drv_lat.sv
// Issue-length decode (3 cycles for multiplies, 2 otherwise) and the issue down-counter.
module alu_drv_lat
  import alu_cmd_driver_pkg::*;
#(
  parameter int unsigned CMD_WIDTH = ALU_CMD_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [CMD_WIDTH-1:0] code,
  input  logic                 load,
  input  logic                 dec,
  output logic                 last
);

  logic       is_mul;
  logic [1:0] cnt_q, cnt_d;

  assign is_mul = mode && ((code == CMD_WIDTH'(INC_MUL)) || (code == CMD_WIDTH'(SHL_MUL)));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = is_mul ? 2'd3 : 2'd2;
    end else if (dec && (cnt_q != 2'd0)) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == 2'd1);

endmodule

// File: rtl/alu_cmd_driver.sv
// Single-outstanding command initiator for the ALU: holds the command on the ALU for its
// pipeline latency, captures result and flags, returns them with the tag. Optional
// saturating statistics counters are enabled by defining ALU_DRV_STATS_EN.
module alu_cmd_driver
  import alu_cmd_driver_pkg::*;
#(
  parameter int unsigned OP_WIDTH  = ALU_OP_WIDTH,
  parameter int unsigned CMD_WIDTH = ALU_CMD_WIDTH,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_mode,
  input  logic [CMD_WIDTH-1:0]  cmd_code,
  input  logic                  cmd_cin,
  input  logic [1:0]            cmd_inp_valid,
  input  logic [OP_WIDTH-1:0]   cmd_opa,
  input  logic [OP_WIDTH-1:0]   cmd_opb,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  output logic                  alu_ce,
  output logic                  alu_mode,
  output logic [CMD_WIDTH-1:0]  alu_cmd,
  output logic                  alu_cin,
  output logic [1:0]            alu_inp_valid,
  output logic [OP_WIDTH-1:0]   alu_opa,
  output logic [OP_WIDTH-1:0]   alu_opb,
  input  logic [2*OP_WIDTH-1:0] alu_res,
  input  logic                  alu_cout,
  input  logic                  alu_oflow,
  input  logic                  alu_g,
  input  logic                  alu_l,
  input  logic                  alu_e,
  input  logic                  alu_err,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*OP_WIDTH-1:0] rsp_res,
  output logic [5:0]            rsp_flags,
`ifdef ALU_DRV_STATS_EN
  output logic [15:0]           stat_issued,
  output logic [15:0]           stat_errors,
`endif
  output logic [TAG_WIDTH-1:0]  rsp_tag
);

  logic [1:0]           state_q, state_d;
  logic                 accept;
  logic                 capture;
  logic                 issue_last;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [5:0]           flags_in;

  assign accept    = (state_q == IDLE) && cmd_valid;
  assign capture   = (state_q == CAPTURE);
  assign cmd_ready = (state_q == IDLE);
  assign alu_ce    = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP);

  alu_drv_lat #(
    .CMD_WIDTH(CMD_WIDTH)
  ) u_lat (
    .clk  (clk),
    .rst_n(rst_n),
    .mode (cmd_mode),
    .code (cmd_code),
    .load (accept),
    .dec  (alu_ce),
    .last (issue_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = ISSUE;
      ISSUE:   if (issue_last) state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flags_in             = 6'd0;
    flags_in[FLAG_COUT]  = alu_cout;
    flags_in[FLAG_OFLOW] = alu_oflow;
    flags_in[FLAG_G]     = alu_g;
    flags_in[FLAG_L]     = alu_l;
    flags_in[FLAG_E]     = alu_e;
    flags_in[FLAG_ERR]   = alu_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command is latched once at accept and held unchanged through the whole issue window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_mode      <= 1'b0;
      alu_cmd       <= '0;
      alu_cin       <= 1'b0;
      alu_inp_valid <= 2'b00;
      alu_opa       <= '0;
      alu_opb       <= '0;
      tag_q         <= '0;
    end else if (accept) begin
      alu_mode      <= cmd_mode;
      alu_cmd       <= cmd_code;
      alu_cin       <= cmd_cin;
      alu_inp_valid <= cmd_inp_valid;
      alu_opa       <= cmd_opa;
      alu_opb       <= cmd_opb;
      tag_q         <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_res   <= '0;
      rsp_flags <= 6'd0;
      rsp_tag   <= '0;
    end else if (capture) begin
      rsp_res   <= alu_res;
      rsp_flags <= flags_in;
      rsp_tag   <= tag_q;
    end
  end

`ifdef ALU_DRV_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= 16'd0;
      stat_errors <= 16'd0;
    end else begin
      if (accept && (stat_issued != 16'hFFFF)) begin
        stat_issued <= stat_issued + 16'd1;
      end
      if (capture && alu_err && (stat_errors != 16'hFFFF)) begin
        stat_errors <= stat_errors + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver with a behavioural pipelined ALU stub.
module tb_alu_cmd_driver;
  import alu_cmd_driver_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_mode = 1'b0;
  logic [3:0]  cmd_code = 4'd0;
  logic        cmd_cin = 1'b0;
  logic [1:0]  cmd_inp_valid = 2'b00;
  logic [7:0]  cmd_opa = 8'd0;
  logic [7:0]  cmd_opb = 8'd0;
  logic [3:0]  cmd_tag = 4'd0;
  logic        alu_ce;
  logic        alu_mode;
  logic [3:0]  alu_cmd;
  logic        alu_cin;
  logic [1:0]  alu_inp_valid;
  logic [7:0]  alu_opa;
  logic [7:0]  alu_opb;
  logic [15:0] alu_res;
  logic        alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_res;
  logic [5:0]  rsp_flags;
  logic [3:0]  rsp_tag;
`ifdef ALU_DRV_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_errors;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_cmd_driver #(
    .OP_WIDTH (8),
    .CMD_WIDTH(4),
    .TAG_WIDTH(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_code     (cmd_code),
    .cmd_cin      (cmd_cin),
    .cmd_inp_valid(cmd_inp_valid),
    .cmd_opa      (cmd_opa),
    .cmd_opb      (cmd_opb),
    .cmd_tag      (cmd_tag),
    .alu_ce       (alu_ce),
    .alu_mode     (alu_mode),
    .alu_cmd      (alu_cmd),
    .alu_cin      (alu_cin),
    .alu_inp_valid(alu_inp_valid),
    .alu_opa      (alu_opa),
    .alu_opb      (alu_opb),
    .alu_res      (alu_res),
    .alu_cout     (alu_cout),
    .alu_oflow    (alu_oflow),
    .alu_g        (alu_g),
    .alu_l        (alu_l),
    .alu_e        (alu_e),
    .alu_err      (alu_err),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_res      (rsp_res),
    .rsp_flags    (rsp_flags),
`ifdef ALU_DRV_STATS_EN
    .stat_issued  (stat_issued),
    .stat_errors  (stat_errors),
`endif
    .rsp_tag      (rsp_tag)
  );

  // Behavioural ALU: returns {flags[5:0] = {err,e,l,g,oflow,cout}, res[15:0]}.
  function automatic logic [21:0] alu_f(input logic m, input logic [3:0] c, input logic [1:0] iv,
                                        input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic [5:0]  f;
    logic [8:0]  s;
    logic [7:0]  sh;
    r = 16'd0;
    f = 6'd0;
    s = 9'd0;
    sh = 8'(a << 1);
    if (iv != 2'b11) begin
      f[5] = 1'b1;
    end else if (m) begin
      case (c)
        4'd0:    begin s = {1'b0, a} + {1'b0, b}; r = {7'd0, s}; f[0] = s[8]; end
        4'd1:    begin r = {8'd0, 8'(a - b)}; f[1] = (a < b); end
        4'd8:    begin f[2] = (a > b); f[3] = (a < b); f[4] = (a == b); end
        4'd9:    r = ({8'd0, a} + 16'd1) * ({8'd0, b} + 16'd1);
        4'd10:   r = {8'd0, sh} * {8'd0, b};
        default: f[5] = 1'b1;
      endcase
    end else begin
      case (c)
        4'd0:    r = {8'd0, a & b};
        4'd2:    r = {8'd0, a | b};
        4'd4:    r = {8'd0, a ^ b};
        default: f[5] = 1'b1;
      endcase
    end
    return {f, r};
  endfunction

  // ALU stub pipeline: 2 enabled edges for ordinary ops, 3 for multiplies.
  logic [21:0] p1 = '0, p2 = '0, p3 = '0;
  logic        stub_mul;
  logic [21:0] stub_out;
  always @(posedge clk) begin
    if (alu_ce) begin
      p1 <= alu_f(alu_mode, alu_cmd, alu_inp_valid, alu_opa, alu_opb);
      p2 <= p1;
      p3 <= p2;
    end
  end
  assign stub_mul = alu_mode && ((alu_cmd == 4'd9) || (alu_cmd == 4'd10));
  assign stub_out = stub_mul ? p3 : p2;
  assign alu_res = stub_out[15:0];
  assign {alu_err, alu_e, alu_l, alu_g, alu_oflow, alu_cout} = stub_out[21:16];

  typedef struct {
    logic        mode;
    logic [3:0]  code;
    logic        cin;
    logic [1:0]  iv;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  tag;
    logic [15:0] res;
    logic [5:0]  flags;
    int          rv;
    int          ce;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cmd_mode = v.mode;
    cmd_code = v.code;
    cmd_cin = v.cin;
    cmd_inp_valid = v.iv;
    cmd_opa = v.a;
    cmd_opb = v.b;
    cmd_tag = v.tag;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    logic [21:0] o;
    int lat;
    v.mode = 1'($urandom_range(0, 1));
    v.code = 4'($urandom_range(0, 10));
    v.cin = 1'($urandom_range(0, 1));
    v.iv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
    v.a = 8'($urandom);
    v.b = 8'($urandom);
    v.tag = 4'($urandom);
    o = alu_f(v.mode, v.code, v.iv, v.a, v.b);
    v.res = o[15:0];
    v.flags = o[21:16];
    lat = (v.mode && (v.code == 4'd9 || v.code == 4'd10)) ? 3 : 2;
    v.ce = lat;
    v.rv = lat + 2;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; that negedge is cycle 0.
  task automatic run_vec(input vec_t v, input int hold, input bit nxt_en, input vec_t nxt);
    int rv, ce, fwd_bad, rdy_bad, hold_bad;
    rv = 0; ce = 0; fwd_bad = 0; rdy_bad = 0; hold_bad = 0;
    chk("cmd_ready_idle", cmd_ready, 1);
    drive(v);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 20 && rv == 0; c++) begin
      if (alu_ce) begin
        ce++;
        if (alu_opa !== v.a || alu_opb !== v.b || alu_cmd !== v.code || alu_mode !== v.mode ||
            alu_cin !== v.cin || alu_inp_valid !== v.iv) fwd_bad++;
      end
      if (cmd_ready) rdy_bad++;
      if (rsp_valid) rv = c;
      else @(negedge clk);
    end
    chk("rsp_valid_cycle", rv, v.rv);
    chk("alu_ce_cycles", ce, v.ce);
    chk("alu_fields_held", fwd_bad, 0);
    chk("cmd_ready_busy", rdy_bad, 0);
    chk("rsp_res", rsp_res, v.res);
    chk("rsp_flags", rsp_flags, v.flags);
    chk("rsp_tag", rsp_tag, v.tag);
    for (int h = 0; h < hold; h++) begin
      if (nxt_en) begin
        drive(nxt);
        cmd_valid = 1'b1;
      end
      @(negedge clk);
      if (!rsp_valid || rsp_res !== v.res || rsp_flags !== v.flags || rsp_tag !== v.tag ||
          alu_ce || cmd_ready) hold_bad++;
    end
    if (hold > 0) chk("resp_hold_stable", hold_bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("cmd_ready_after_hs", cmd_ready, 1);
  endtask

  vec_t tbl[8];
  vec_t dummy;

  initial begin
    tbl[0] = '{1'b1, 4'(ADD), 1'b0, 2'b11, 8'h0F, 8'h01, 4'd3, 16'h0010, 6'b000000, 4, 2};
    tbl[1] = '{1'b1, 4'(INC_MUL), 1'b0, 2'b11, 8'h03, 8'h04, 4'd5, 16'h0014, 6'b000000, 5, 3};
    tbl[2] = '{1'b1, 4'(ADD), 1'b0, 2'b01, 8'h0F, 8'h01, 4'd7, 16'h0000, 6'b100000, 4, 2};
    tbl[3] = '{1'b1, 4'(SHL_MUL), 1'b1, 2'b11, 8'h03, 8'h04, 4'd9, 16'h0018, 6'b000000, 5, 3};
    tbl[4] = '{1'b0, 4'd9, 1'b0, 2'b11, 8'h12, 8'h34, 4'd1, 16'h0000, 6'b100000, 4, 2};
    tbl[5] = '{1'b1, 4'(ADD), 1'b0, 2'b11, 8'hFF, 8'h01, 4'd15, 16'h0100, 6'b000001, 4, 2};
    tbl[6] = '{1'b1, 4'(CMP), 1'b0, 2'b11, 8'h05, 8'h09, 4'd2, 16'h0000, 6'b001000, 4, 2};
    tbl[7] = '{1'b0, 4'd0, 1'b0, 2'b11, 8'hF0, 8'h3C, 4'd4, 16'h0030, 6'b000000, 4, 2};
    dummy = tbl[0];

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_alu_ce", alu_ce, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_data", {alu_mode, alu_cmd, alu_cin, alu_inp_valid, alu_opa, alu_opb}, 0);
    chk("reset_rsp_data", {rsp_res, rsp_flags, rsp_tag}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], 0, 1'b0, dummy);

    // Back-pressure with a competing command held on the port
    run_vec(tbl[0], 10, 1'b1, tbl[1]);
    run_vec(tbl[1], 0, 1'b0, dummy);

    // Reset in cycle 2 of a multiply
    begin
      int seen;
      seen = 0;
      drive(tbl[1]);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("mul_ce_cycle1", alu_ce, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_alu_ce", alu_ce, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      chk("midrst_alu_opa", alu_opa, 0);
      chk("midrst_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
        if (rsp_valid || alu_ce) seen++;
        @(negedge clk);
      end
      chk("midrst_no_response", seen, 0);
      chk("midrst_idle", cmd_ready, 1);
    end

    for (int i = 0; i < 30; i++) run_vec(rand_vec(), $urandom_range(0, 3), 1'b0, dummy);

`ifdef ALU_DRV_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("stat_issued_reset", stat_issued, 0);
    run_vec(tbl[0], 0, 1'b0, dummy);
    run_vec(tbl[1], 0, 1'b0, dummy);
    run_vec(tbl[3], 0, 1'b0, dummy);
    run_vec(tbl[2], 0, 1'b0, dummy);
    chk("stat_issued", stat_issued, 4);
    chk("stat_errors", stat_errors, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
